// File: rtl/vram_cpu_port.sv
// 6502-side register port into video RAM: queued writes, prefetched reads, video-priority arbitration.
// Optional VRAM_PORT_STRIDE_EN makes the STATUS register writable as the pointer stride.
module vram_cpu_port #(
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CPU_CS,
    input  logic              CPU_RW,
    input  logic [1:0]        CPU_REG,
    input  logic [7:0]        CPU_DIN,
    output logic [7:0]        CPU_DOUT,
    input  logic              VID_BUSY,
    output logic              VRAM_REQ,
    output logic              VRAM_WE,
    output logic [ADDR_W-1:0] VRAM_ADDR,
    output logic [7:0]        VRAM_DIN,
    input  logic [7:0]        VRAM_DOUT,
    output logic              FIFO_FULL,
    output logic              IDLE
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_RWAIT = 2'd3;

    localparam logic [1:0] R_LO   = 2'd0;
    localparam logic [1:0] R_HI   = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] R_STAT = 2'd3;

    logic [1:0]        state, state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [15:0]       ptr_ext;
    logic [7:0]        stride;
    logic [7:0]        latch;
    logic              pf_valid, pf_pend, ovf;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [IDX_W:0]    count;
    logic              fifo_empty;

    logic wr_lo, wr_hi, wr_data, rd_data, rd_stat;
    logic push, pop, issue_wr, issue_rd, pf_restart;

    assign wr_lo      = CPU_CS && !CPU_RW && (CPU_REG == R_LO);
    assign wr_hi      = CPU_CS && !CPU_RW && (CPU_REG == R_HI);
    assign wr_data    = CPU_CS && !CPU_RW && (CPU_REG == R_DATA);
    assign rd_data    = CPU_CS &&  CPU_RW && (CPU_REG == R_DATA);
    assign rd_stat    = CPU_CS &&  CPU_RW && (CPU_REG == R_STAT);

    assign fifo_empty = (count == '0);
    assign FIFO_FULL  = (count == (IDX_W+1)'(FIFO_DEPTH));
    assign pop        = issue_wr;
    // A full FIFO can still take a push in the same cycle the drain frees a slot.
    assign push       = wr_data && (!FIFO_FULL || pop);
    assign pf_restart = wr_lo || wr_hi || rd_data;
    assign IDLE       = fifo_empty && !pf_pend && (state == S_IDLE);
    assign ptr_ext    = 16'(ptr);

`ifdef VRAM_PORT_STRIDE_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            stride <= 8'd1;
        else if (CPU_CS && !CPU_RW && (CPU_REG == R_STAT))
            stride <= CPU_DIN;
    end
`else
    assign stride = 8'd1;
`endif

    always_comb begin
        case (CPU_REG)
            R_LO:    CPU_DOUT = ptr_ext[7:0];
            R_HI:    CPU_DOUT = ptr_ext[15:8];
            R_DATA:  CPU_DOUT = latch;
            default: CPU_DOUT = {4'b0, ovf, pf_valid, fifo_empty, FIFO_FULL};
        endcase
    end

    // Pending writes always drain before a prefetch so reads see earlier writes.
    always_comb begin
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (!VID_BUSY && !fifo_empty) begin
                    issue_wr = 1'b1;
                    state_nx = S_WRITE;
                end else if (!VID_BUSY && pf_pend) begin
                    issue_rd = 1'b1;
                    state_nx = S_READ;
                end
            end
            S_WRITE: begin
                if (!VID_BUSY && !fifo_empty)
                    issue_wr = 1'b1;
                else
                    state_nx = S_IDLE;
            end
            S_READ:  state_nx = S_RWAIT;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_addr[wr_idx] <= ptr;
            fifo_data[wr_idx] <= CPU_DIN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            ptr       <= '0;
            latch     <= 8'd0;
            pf_valid  <= 1'b0;
            pf_pend   <= 1'b0;
            ovf       <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            count     <= '0;
            VRAM_REQ  <= 1'b0;
            VRAM_WE   <= 1'b0;
            VRAM_ADDR <= '0;
            VRAM_DIN  <= 8'd0;
        end else begin
            state <= state_nx;

            if (wr_lo)
                ptr[7:0] <= CPU_DIN;
            else if (wr_hi)
                ptr[ADDR_W-1:8] <= CPU_DIN[ADDR_W-9:0];
            else if (push || rd_data)
                ptr <= ptr + ADDR_W'(stride);

            if (wr_data && !push)
                ovf <= 1'b1;
            else if (rd_stat)
                ovf <= 1'b0;

            if (push)
                wr_idx <= wr_idx + IDX_W'(1);
            if (pop)
                rd_idx <= rd_idx + IDX_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (IDX_W+1)'(1);
                2'b01:   count <= count - (IDX_W+1)'(1);
                default: count <= count;
            endcase

            // A pointer change during an in-flight fetch discards its result.
            if (pf_restart)
                pf_pend <= 1'b1;
            else if (issue_rd)
                pf_pend <= 1'b0;

            if (pf_restart)
                pf_valid <= 1'b0;
            else if ((state == S_RWAIT) && !pf_pend)
                pf_valid <= 1'b1;

            if ((state == S_RWAIT) && !pf_pend && !pf_restart)
                latch <= VRAM_DOUT;

            if (issue_wr) begin
                VRAM_REQ  <= 1'b1;
                VRAM_WE   <= 1'b1;
                VRAM_ADDR <= fifo_addr[rd_idx];
                VRAM_DIN  <= fifo_data[rd_idx];
            end else if (issue_rd) begin
                VRAM_REQ  <= 1'b1;
                VRAM_WE   <= 1'b0;
                VRAM_ADDR <= ptr;
            end else begin
                VRAM_REQ  <= 1'b0;
                VRAM_WE   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_cpu_port.sv
// Directed bench for vram_cpu_port: VRAM model, write scoreboard and register read-back checks.
// Honours VRAM_PORT_STRIDE_EN for the stride sequence.
module tb_vram_cpu_port;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CPU_CS;
    logic        CPU_RW;
    logic [1:0]  CPU_REG;
    logic [7:0]  CPU_DIN;
    logic [7:0]  CPU_DOUT;
    logic        VID_BUSY;
    logic        VRAM_REQ;
    logic        VRAM_WE;
    logic [13:0] VRAM_ADDR;
    logic [7:0]  VRAM_DIN;
    logic [7:0]  VRAM_DOUT = 8'd0;
    logic        FIFO_FULL;
    logic        IDLE;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int wr_count   = 0;
    int last_wr_cyc = 0;
    int prev_wr_cyc = 0;

    logic [21:0] sb [$];
    logic [7:0]  vram    [16384];
    logic [7:0]  exp_mem [16384];
    logic [13:0] model_ptr;
    logic [7:0]  model_stride;

    vram_cpu_port #(.ADDR_W(14), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RESET(RESET), .CPU_CS(CPU_CS), .CPU_RW(CPU_RW), .CPU_REG(CPU_REG),
        .CPU_DIN(CPU_DIN), .CPU_DOUT(CPU_DOUT), .VID_BUSY(VID_BUSY), .VRAM_REQ(VRAM_REQ),
        .VRAM_WE(VRAM_WE), .VRAM_ADDR(VRAM_ADDR), .VRAM_DIN(VRAM_DIN), .VRAM_DOUT(VRAM_DOUT),
        .FIFO_FULL(FIFO_FULL), .IDLE(IDLE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Registered-read video RAM
    always @(posedge CLK) begin
        if (VRAM_REQ) begin
            if (VRAM_WE)
                vram[VRAM_ADDR] = VRAM_DIN;
            else
                VRAM_DOUT <= vram[VRAM_ADDR];
        end
    end

    function automatic logic [7:0] init_val(int a);
        return 8'(a ^ (a >> 8) ^ 32'h5C);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge CLK) begin
        logic [21:0] e;
        if (!RESET && VRAM_REQ && VRAM_WE) begin
            wr_count++;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $error("[TB] FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write",
                       VRAM_ADDR, VRAM_DIN);
            end else begin
                e = sb.pop_front();
                checkOutput("vram_write", {10'b0, VRAM_ADDR, VRAM_DIN}, {10'b0, e});
            end
        end
    end

    task automatic applyStimulus(input logic rw, input logic [1:0] sel, input logic [7:0] din,
                                 output logic [7:0] dout);
        @(negedge CLK);
        CPU_CS  = 1'b1;
        CPU_RW  = rw;
        CPU_REG = sel;
        CPU_DIN = din;
        #1 dout = CPU_DOUT;
        @(posedge CLK);
        #1;
        CPU_CS = 1'b0;
        CPU_RW = 1'b1;
    endtask

    task automatic cpuWrite(input logic [1:0] sel, input logic [7:0] din);
        logic [7:0] d;
        applyStimulus(1'b0, sel, din, d);
    endtask

    task automatic cpuRead(input logic [1:0] sel, output logic [7:0] d);
        applyStimulus(1'b1, sel, 8'h00, d);
    endtask

    task automatic setPtr(input logic [13:0] p);
        cpuWrite(2'd0, p[7:0]);
        cpuWrite(2'd1, {2'b00, p[13:8]});
        model_ptr = p;
    endtask

    task automatic dataWrite(input logic [7:0] din, input bit accept);
        cpuWrite(2'd2, din);
        if (accept) begin
            sb.push_back({model_ptr, din});
            exp_mem[model_ptr] = din;
            model_ptr += 14'(model_stride);
        end
    endtask

    task automatic dataRead(input string tag);
        logic [7:0] d;
        logic [7:0] expv;
        expv = exp_mem[model_ptr];
        cpuRead(2'd2, d);
        checkOutput(tag, d, expv);
        model_ptr += 14'(model_stride);
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (IDLE !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checkOutput(tag, IDLE, 1);
    endtask

    task automatic doReset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        sb.delete();
        model_ptr    = 14'd0;
        model_stride = 8'd1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] d;
        int base;
        int n;

        RESET    = 1'b1;
        CPU_CS   = 1'b0;
        CPU_RW   = 1'b1;
        CPU_REG  = 2'd0;
        CPU_DIN  = 8'd0;
        VID_BUSY = 1'b0;
        model_ptr    = 14'd0;
        model_stride = 8'd1;
        for (int i = 0; i < 16384; i++) begin
            vram[i]    = init_val(i);
            exp_mem[i] = init_val(i);
        end
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Reset state
        checkOutput("rst_req", VRAM_REQ, 0);
        checkOutput("rst_we", VRAM_WE, 0);
        checkOutput("rst_addr", VRAM_ADDR, 0);
        checkOutput("rst_din", VRAM_DIN, 0);
        checkOutput("rst_full", FIFO_FULL, 0);
        checkOutput("rst_idle", IDLE, 1);
        CPU_REG = 2'd2;
        #1 checkOutput("rst_latch", CPU_DOUT, 8'h00);
        CPU_REG = 2'd3;
        #1 checkOutput("rst_status", CPU_DOUT, 8'h02);
        CPU_REG = 2'd0;

        // Basic writes drain back to back
        setPtr(14'h1234);
        dataWrite(8'hAA, 1);
        dataWrite(8'hBB, 1);
        waitIdle("t1_idle");
        checkOutput("t1_drained", sb.size(), 0);
        checkOutput("t1_wr_count", wr_count, 2);
        checkOutput("t1_consecutive", last_wr_cyc - prev_wr_cyc, 1);
        cpuRead(2'd0, d);
        checkOutput("t1_ptr_lo", d, 8'h36);
        cpuRead(2'd1, d);
        checkOutput("t1_ptr_hi", d, 8'h12);

        // Overflow while video owns the RAM
        doReset();
        base = wr_count;
        VID_BUSY = 1'b1;
        dataWrite(8'hC0, 1);
        dataWrite(8'hC1, 1);
        dataWrite(8'hC2, 1);
        dataWrite(8'hC3, 1);
        checkOutput("t2_full", FIFO_FULL, 1);
        dataWrite(8'hC4, 0);
        checkOutput("t2_no_issue", wr_count - base, 0);
        cpuRead(2'd3, d);
        checkOutput("t2_status_ovf", d, 8'h09);
        cpuRead(2'd0, d);
        checkOutput("t2_ptr_held", d, 8'h04);
        VID_BUSY = 1'b0;
        waitIdle("t2_idle");
        checkOutput("t2_drained", sb.size(), 0);
        checkOutput("t2_wr_count", wr_count - base, 4);
        cpuRead(2'd3, d);
        checkOutput("t2_status_clr", d, 8'h02);

        // Pointer wrap and sequential prefetched reads
        cpuWrite(2'd0, 8'hFF);
        cpuWrite(2'd1, 8'hFF);
        model_ptr = 14'h3FFF;
        cpuRead(2'd1, d);
        checkOutput("t3_hi_masked", d, 8'h3F);
        dataWrite(8'h77, 1);
        cpuRead(2'd0, d);
        checkOutput("t3_wrap_lo", d, 8'h00);
        cpuRead(2'd1, d);
        checkOutput("t3_wrap_hi", d, 8'h00);
        setPtr(14'h0010);
        waitIdle("t3_idle0");
        cpuRead(2'd3, d);
        checkOutput("t3_status_pf", d, 8'h06);
        dataRead("t3_read_0010");
        waitIdle("t3_idle1");
        dataRead("t3_read_0011");

        // Read after queued write at the same address is coherent
        setPtr(14'h0200);
        dataWrite(8'h5A, 1);
        setPtr(14'h0200);
        waitIdle("t4_idle");
        checkOutput("t4_drained", sb.size(), 0);
        dataRead("t4_read_0200");

        // Reset in the middle of a drain
        doReset();
        VID_BUSY = 1'b1;
        dataWrite(8'hD0, 1);
        dataWrite(8'hD1, 1);
        dataWrite(8'hD2, 1);
        VID_BUSY = 1'b0;
        n = 0;
        while (!(VRAM_REQ === 1'b1 && VRAM_WE === 1'b1) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("t5_write_seen", VRAM_WE, 1);
        #2 RESET = 1'b1;
        #1;
        checkOutput("t5_rst_we", VRAM_WE, 0);
        checkOutput("t5_rst_req", VRAM_REQ, 0);
        checkOutput("t5_rst_addr", VRAM_ADDR, 0);
        sb.delete();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        model_ptr    = 14'd0;
        model_stride = 8'd1;
        base = wr_count;
        repeat (10) @(negedge CLK);
        checkOutput("t5_no_write", wr_count - base, 0);
        checkOutput("t5_idle", IDLE, 1);

        // Stride register
        doReset();
        cpuWrite(2'd3, 8'd80);
`ifdef VRAM_PORT_STRIDE_EN
        model_stride = 8'd80;
`endif
        setPtr(14'h0000);
        dataWrite(8'hE0, 1);
        dataWrite(8'hE1, 1);
        dataWrite(8'hE2, 1);
        waitIdle("t6_idle");
        checkOutput("t6_drained", sb.size(), 0);
        cpuRead(2'd0, d);
`ifdef VRAM_PORT_STRIDE_EN
        checkOutput("t6_ptr_lo", d, 8'd240);
`else
        checkOutput("t6_ptr_lo", d, 8'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
